// File: rtl/cg_enable_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cg_enable_ctrl_if
// Brief    : Request/enable bundle between a domain manager and cg_enable_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface cg_enable_ctrl_if #(
  parameter int NUM_DOMAINS = 4
);
  logic [NUM_DOMAINS-1:0] req;
  logic                   force_on;
  logic [NUM_DOMAINS-1:0] en;
  logic [NUM_DOMAINS-1:0] ack;
  logic                   idle_all;

  modport master (output req, output force_on, input en, input ack, input idle_all);
  modport slave  (input req, input force_on, output en, output ack, output idle_all);
endinterface
`default_nettype wire

// File: rtl/cg_enable_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cg_enable_ctrl
// Brief    : Per-domain CLKGATE_X1 enable sequencer with idle hysteresis and
//            parent/child ordering for cascaded gates.
// Revision : 1.0 - initial release
// ============================================================================
module cg_enable_ctrl #(
  parameter int                     NUM_DOMAINS = 4,
  parameter int                     IDLE_CYCLES = 16,
  parameter logic [NUM_DOMAINS-1:0] PARENT_MASK = NUM_DOMAINS'(1)
) (
  input  logic             clk,
  input  logic             rst,
  cg_enable_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam bit         C_HAS_IDLE  = (IDLE_CYCLES > 0);
  localparam logic [7:0] C_HOLD_LOAD = C_HAS_IDLE ? 8'(IDLE_CYCLES - 1) : 8'd0;

  state_t                 state_q [NUM_DOMAINS];
  state_t                 state_d [NUM_DOMAINS];
  logic [7:0]             cnt_q   [NUM_DOMAINS];
  logic [7:0]             cnt_d   [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] en_q, en_d;
  logic [NUM_DOMAINS-1:0] ack_q, ack_d;
  logic                   idle_all_q, idle_all_d;

  logic [NUM_DOMAINS-1:0] w_act;
  logic [NUM_DOMAINS-1:0] w_pok;
  logic [NUM_DOMAINS:0]   w_ack_ext;

  always_comb begin : p_next
    logic v_child;
    v_child    = 1'b0;
    w_ack_ext  = {1'b1, ack_q};
    w_act      = '0;
    w_pok      = '0;
    en_d       = '0;
    ack_d      = '0;
    idle_all_d = 1'b1;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      // A child's demand (even while it waits on us) keeps the parent active.
      w_act[i]   = bus.req[i] | v_child;
      w_pok[i]   = ~PARENT_MASK[i] | w_ack_ext[i+1];

      case (state_q[i])
        S_OFF:  if (w_act[i] && w_pok[i]) state_d[i] = S_WAKE;
        S_WAKE: state_d[i] = S_ON;
        S_ON: begin
          if (!w_act[i]) begin
            if (C_HAS_IDLE) begin
              state_d[i] = S_HOLD;
              cnt_d[i]   = C_HOLD_LOAD;
            end else begin
              state_d[i] = S_OFF;
            end
          end
        end
        S_HOLD: begin
          if (w_act[i])             state_d[i] = S_ON;
          else if (cnt_q[i] == 8'd0) state_d[i] = S_OFF;
          else                      cnt_d[i]   = cnt_q[i] - 8'd1;
        end
        default: state_d[i] = S_OFF;
      endcase

      en_d[i]    = (state_d[i] != S_OFF) | bus.force_on;
      ack_d[i]   = (state_d[i] == S_ON) || (state_d[i] == S_HOLD);
      idle_all_d = idle_all_d & (state_q[i] == S_OFF);
      v_child    = PARENT_MASK[i] & (w_act[i] | (state_q[i] != S_OFF));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= 8'd0;
      end
      en_q       <= '0;
      ack_q      <= '0;
      idle_all_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      ack_q      <= ack_d;
      idle_all_q <= idle_all_d;
    end
  end

  assign bus.en       = en_q;
  assign bus.ack      = ack_q;
  assign bus.idle_all = idle_all_q;

endmodule
`default_nettype wire

// File: tb/tb_cg_enable_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cg_enable_ctrl
// Brief    : Directed scoreboard bench for cg_enable_ctrl (IDLE 16 / 4 / 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cg_enable_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cg_enable_ctrl_if #(.NUM_DOMAINS(4)) if_a ();
  cg_enable_ctrl_if #(.NUM_DOMAINS(4)) if_b ();
  cg_enable_ctrl_if #(.NUM_DOMAINS(4)) if_c ();

  cg_enable_ctrl #(.NUM_DOMAINS(4), .IDLE_CYCLES(16), .PARENT_MASK(4'b0001))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  cg_enable_ctrl #(.NUM_DOMAINS(4), .IDLE_CYCLES(4), .PARENT_MASK(4'b0001))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  cg_enable_ctrl #(.NUM_DOMAINS(4), .IDLE_CYCLES(0), .PARENT_MASK(4'b0001))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  typedef struct {
    string      tag;
    int         dut;
    logic [3:0] en;
    logic [3:0] ack;
    logic       idle;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push(input string tag, input int dut, input logic [3:0] en,
                      input logic [3:0] ack, input logic idle);
    exp_t e;
    e.tag = tag; e.dut = dut; e.en = en; e.ack = ack; e.idle = idle;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [3:0] o_en, o_ack;
    logic       o_idle;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin o_en = if_a.en; o_ack = if_a.ack; o_idle = if_a.idle_all; end
        1:       begin o_en = if_b.en; o_ack = if_b.ack; o_idle = if_b.idle_all; end
        default: begin o_en = if_c.en; o_ack = if_c.ack; o_idle = if_c.idle_all; end
      endcase
      n_checks++;
      assert (o_en === e.en) n_pass++;
      else $error("FAIL %s.en dut%0d observed=%b expected=%b", e.tag, e.dut, o_en, e.en);
      n_checks++;
      assert (o_ack === e.ack) n_pass++;
      else $error("FAIL %s.ack dut%0d observed=%b expected=%b", e.tag, e.dut, o_ack, e.ack);
      n_checks++;
      assert (o_idle === e.idle) n_pass++;
      else $error("FAIL %s.idle dut%0d observed=%b expected=%b", e.tag, e.dut, o_idle, e.idle);
    end
  endtask

  // Expectation describes outputs just after the next rising edge.
  task automatic step(input string tag, input int dut, input logic [3:0] en,
                      input logic [3:0] ack, input logic idle);
    push(tag, dut, en, ack, idle);
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic steps(input int n, input string tag, input int dut, input logic [3:0] en,
                       input logic [3:0] ack, input logic idle);
    for (int k = 0; k < n; k++) step(tag, dut, en, ack, idle);
  endtask

  initial begin
    if_a.req = '0; if_a.force_on = 1'b0;
    if_b.req = '0; if_b.force_on = 1'b0;
    if_c.req = '0; if_c.force_on = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    push("rst_a", 0, 4'b0000, 4'b0000, 1'b1);
    push("rst_b", 1, 4'b0000, 4'b0000, 1'b1);
    push("rst_c", 2, 4'b0000, 4'b0000, 1'b1);
    drain();
    @(negedge clk);
    rst = 1'b0;

    // Test 1: async reset with domain 2 running
    if_a.req = 4'b0100;
    step("t1_wake", 0, 4'b0100, 4'b0000, 1'b1);
    step("t1_on",   0, 4'b0100, 4'b0100, 1'b0);
    #4;
    rst = 1'b1;
    #1;
    push("t1_async", 0, 4'b0000, 4'b0000, 1'b1);
    drain();
    if_a.req = 4'b0000;
    steps(2, "t1_inrst", 0, 4'b0000, 4'b0000, 1'b1);
    rst = 1'b0;
    steps(3, "t1_after", 0, 4'b0000, 4'b0000, 1'b1);

    // Test 2: root wake/sleep on domain 3
    if_a.req = 4'b1000;
    step ("t2_en",   0, 4'b1000, 4'b0000, 1'b1);
    steps(4, "t2_on", 0, 4'b1000, 4'b1000, 1'b0);
    if_a.req = 4'b0000;
    steps(16, "t2_hold", 0, 4'b1000, 4'b1000, 1'b0);
    step ("t2_off",  0, 4'b0000, 4'b0000, 1'b0);
    step ("t2_idle", 0, 4'b0000, 4'b0000, 1'b1);

    // Test 3: cascade, domain 0 clocked from domain 1
    if_a.req = 4'b0001;
    step ("t3_pen",  0, 4'b0010, 4'b0000, 1'b1);
    step ("t3_pack", 0, 4'b0010, 4'b0010, 1'b0);
    step ("t3_cen",  0, 4'b0011, 4'b0010, 1'b0);
    steps(5, "t3_on", 0, 4'b0011, 4'b0011, 1'b0);
    if_a.req = 4'b0000;
    steps(16, "t3_chold", 0, 4'b0011, 4'b0011, 1'b0);
    steps(17, "t3_phold", 0, 4'b0010, 4'b0010, 1'b0);
    step ("t3_off",  0, 4'b0000, 4'b0000, 1'b0);
    step ("t3_idle", 0, 4'b0000, 4'b0000, 1'b1);

    // Test 4: hysteresis retrigger, IDLE_CYCLES=4
    if_b.req = 4'b0100;
    step ("t4_en",   1, 4'b0100, 4'b0000, 1'b1);
    steps(2, "t4_on", 1, 4'b0100, 4'b0100, 1'b0);
    if_b.req = 4'b0000;
    steps(3, "t4_low3", 1, 4'b0100, 4'b0100, 1'b0);
    if_b.req = 4'b0100;
    steps(2, "t4_rehi", 1, 4'b0100, 4'b0100, 1'b0);
    if_b.req = 4'b0000;
    steps(4, "t4_low4", 1, 4'b0100, 4'b0100, 1'b0);
    step ("t4_off",  1, 4'b0000, 4'b0000, 1'b0);
    step ("t4_idle", 1, 4'b0000, 4'b0000, 1'b1);

    // Test 5: IDLE_CYCLES=0, single-cycle request
    if_c.req = 4'b1000;
    step("t5_en",   2, 4'b1000, 4'b0000, 1'b1);
    if_c.req = 4'b0000;
    step("t5_on",   2, 4'b1000, 4'b1000, 1'b0);
    step("t5_off",  2, 4'b0000, 4'b0000, 1'b0);
    step("t5_idle", 2, 4'b0000, 4'b0000, 1'b1);

    // Test 6: force_on while idle
    if_a.force_on = 1'b1;
    steps(2, "t6_force", 0, 4'b1111, 4'b0000, 1'b1);
    if_a.force_on = 1'b0;
    step ("t6_rel",  0, 4'b0000, 4'b0000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
